booth_seq_mul: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier with valid/ready handshakes. It is the sequential successor to the team's 8×8 combinational `boothmul`. It adds configurable operand width, a per-operation signed/unsigned select, and output backpressure. It retires one Booth digit per clock and sits between operand-producing datapaths and any consumer that can stall.

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_r4_digit.sv | 29 ++
 rtl/booth_seq_mul.sv | 108 ++++++++++
 tb/tb_booth_seq_mul.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } booth_state_e;

  typedef enum logic [2:0] {
    DigZero,
    DigPos1,
    DigPos2,
    DigNeg1,
    DigNeg2
  } booth_digit_e;

  // One extra digit absorbs the zero-extension bit of unsigned operands.
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e sel;
    unique case (win)
      3'b000, 3'b111: sel = DigZero;
      3'b001, 3'b010: sel = DigPos1;
      3'b011:         sel = DigPos2;
      3'b100:         sel = DigNeg2;
      default:        sel = DigNeg1;  // 3'b101, 3'b110
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth recoder: maps a 3-bit multiplier window and the
// aligned multiplicand to the signed partial product.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]         win,
  input  logic [2*WIDTH+1:0] mcand,
  output logic [2*WIDTH+1:0] pp
);

  booth_digit_e sel;

  assign sel = booth_decode(win);

  always_comb begin
    pp = '0;
    unique case (sel)
      DigZero: pp = '0;
      DigPos1: pp = mcand;
      DigPos2: pp = mcand << 1;
      DigNeg1: pp = -mcand;
      DigNeg2: pp = -(mcand << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned AccW   = 2 * WIDTH + 2;
  localparam int unsigned MregW  = WIDTH + 3;
  localparam int unsigned Digits = booth_digits(WIDTH);
  localparam int unsigned CntW   = $clog2(Digits + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_seq_mul: WIDTH must be even and at least 4");
  end

  booth_state_e     state_q;
  logic [AccW-1:0]  acc_q;
  logic [AccW-1:0]  mcand_q;
  logic [MregW-1:0] mreg_q;
  logic [MregW-1:0] mreg_sh;
  logic [CntW-1:0]  cnt_q;
  logic [AccW-1:0]  pp;
  logic             last_digit;
  logic             xa;
  logic             xb;
  logic             unused_acc_msb;

  booth_r4_digit #(
    .WIDTH (WIDTH)
  ) u_digit (
    .win   (mreg_q[2:0]),
    .mcand (mcand_q),
    .pp    (pp)
  );

  assign xa      = tc & a[WIDTH-1];
  assign xb      = tc & b[WIDTH-1];
  assign mreg_sh = $signed(mreg_q) >>> 2;

`ifdef BOOTH_EARLY_TERM_EN
  // An all-0s or all-1s remainder only produces zero digits from here on.
  assign last_digit = (cnt_q == CntW'(Digits - 1)) || (&mreg_sh) || (~|mreg_sh);
`else
  assign last_digit = (cnt_q == CntW'(Digits - 1));
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign p         = acc_q[2*WIDTH-1:0];

  // The two guard bits only matter for intermediate sums; the final product fits exactly.
  assign unused_acc_msb = ^acc_q[AccW-1:AccW-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      mreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            acc_q   <= '0;
            mcand_q <= {{(AccW - WIDTH){xa}}, a};
            mreg_q  <= {xb, xb, b, 1'b0};
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q   <= acc_q + pp;
          mcand_q <= mcand_q << 2;
          mreg_q  <= mreg_sh;
          cnt_q   <= cnt_q + 1'b1;
          if (last_digit) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A stalled product must not move.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (out_valid && !out_ready) |=> (out_valid && $stable(p)));

endmodule

// File: tb/tb_booth_seq_mul.sv
// Randomized self-checking bench for booth_seq_mul at WIDTH=8 against an arithmetic model.
module tb_booth_seq_mul;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           tc;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int n_vec;
  int n_err;

  booth_seq_mul #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                             input logic tci);
    longint sa;
    longint sb;
    longint prod;
    sa   = tci ? longint'($signed(ai)) : longint'(ai);
    sb   = tci ? longint'($signed(bi)) : longint'(bi);
    prod = sa * sb;
    return prod[2*W-1:0];
  endfunction

  // Edges from accept to out_valid.
  function automatic int model_lat(input logic [W-1:0] bi, input logic tci);
`ifdef BOOTH_EARLY_TERM_EN
    longint v;
    longint rem;
    v = (tci ? longint'($signed(bi)) : longint'(bi)) * 2;
    for (int k = 1; k <= int'(N); k++) begin
      rem = v >>> (2 * k);
      if (rem == 0 || rem == -1) return k;
    end
    return N + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic tci,
                        input int stall);
    logic [2*W-1:0] exp_p;
    int             lat;
    exp_p = model_p(ai, bi, tci);
    @(negedge clk);
    check_eq("ready_before_load", in_ready, 1'b1);
    a         = ai;
    b         = bi;
    tc        = tci;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    tc        = 1'($urandom);
    out_ready = 1'($urandom);
    check_eq("busy_after_load", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    check_eq("latency", 64'(lat), 64'(model_lat(bi, tci)));
    check_eq("product", p, exp_p);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      tc       = 1'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_p", p, exp_p);
      check_eq("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("taken_valid", out_valid, 1'b0);
    check_eq("taken_ready", in_ready, 1'b1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tc        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_p", p, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hAE, 8'h27, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'hF0, 8'hD0, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'h80, 8'h02, 1'b0, 0);
    run_op(8'h7F, 8'h81, 1'b1, 4);
    run_op(8'hFF, 8'h80, 1'b0, 1);

    // Abort mid-calculation on the second digit edge.
    @(negedge clk);
    a        = 8'h55;
    b        = 8'hC3;
    tc       = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_p", p, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h07, 8'h02, 1'b1, 0);
    run_op(8'h07, 8'h00, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
